// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_entry_t  : one queued fetch {pc, instr}
//   fetch_state_t  : fetch control state (RUN / HALT)
//   PC_STEP        : byte increment between sequential fetches
//   PC_READ_OFFSET : offset between an instruction's PC and the architectural
//                    PC value it observes when reading the PC register
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small in-order queue of fetch_entry_t between instruction memory and decode.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (empties the queue)
//   i_push     in   write i_wr_entry at the tail
//   i_pop      in   remove the head
//   i_flush    in   synchronous flush; overrides push and pop
//   i_wr_entry in   entry to write
//   o_head     out  entry at the head (stale when empty)
//   o_count    out  number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_wr_entry,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    // Control: pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage carries no reset; validity is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage in front of a combinational instruction memory.
// Owns the PC, fetches one word per cycle into fetch_fifo, and hands
// instructions to decode over a valid/ready handshake. A branch redirect
// flushes the queue and reloads the PC. A misaligned or out-of-range PC
// raises a sticky fault (HALT state) that only reset clears.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imem_a   out  32      byte address to instruction memory (= current PC)
//   imem_rd  in   32      instruction word for imem_a (combinational)
//   br_valid, br_target   redirect request and target byte address
//   out_valid/out_ready   handshake to decode
//   out_instr, out_pc     head instruction and its PC
//   out_pc_plus8          out_pc + 8, modulo 2^32
//   fault                 sticky fetch fault
//   fetch_count           pushes since reset        (FETCH_PERF_CNT_EN)
//   flush_count           entries discarded by redirects (FETCH_PERF_CNT_EN)
// Build option: define FETCH_PERF_CNT_EN to include the performance counters;
// otherwise both counter outputs are constant 0.
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8,
    output logic        fault,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_pc;
    fetch_state_t  r_state;
    logic          w_pc_bad;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head;

    assign w_pc_bad = (r_pc[1:0] != 2'b00) || (r_pc[31:2] >= 30'(IMEM_WORDS));

    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full queue still accepts a push
    assign w_push    = (r_state == RUN) && !w_pc_bad && !br_valid &&
                       ((w_count < CW'(DEPTH)) || w_pop);

    assign w_wr_entry.pc    = r_pc;
    assign w_wr_entry.instr = imem_rd;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (br_valid),
        .i_wr_entry (w_wr_entry),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    // PC and fault state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_state <= RUN;
        end else begin
            if (br_valid)    r_pc <= br_target;
            else if (w_push) r_pc <= r_pc + PC_STEP;
            if (r_state == RUN && w_pc_bad) r_state <= HALT;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;

    // Every valid entry is discarded on a redirect, including a same-cycle pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_push)   r_fetch_count <= r_fetch_count + 32'd1;
            if (br_valid) r_flush_count <= r_flush_count + 32'(w_count);
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`else
    assign fetch_count = 32'd0;
    assign flush_count = 32'd0;
`endif

    assign imem_a       = r_pc;
    assign out_instr    = w_head.instr;
    assign out_pc       = w_head.pc;
    assign out_pc_plus8 = w_head.pc + PC_READ_OFFSET;
    assign fault        = (r_state == HALT);

endmodule
